alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Downstream stage of the 8-bit ALU. Captures the ALU result and carry into a one-entry pipeline register.
- On the following edge, commits the staged result to the architectural A, X or Y register and updates the processor status register P (N, V, Z, C).
- Also executes flag-control ops (CLC/SEC/CLI/SEI/CLD/SED/CLV) and PLP loads.
- Provides a forwarded carry back to the ALU carry_in, so back-to-back ADC/SBC/ROL chains see the correct carry.

Parameters:
- P_RESET, 8'h34, reset value of reg_p (I=1; bits 5 and 4 read as 1).
- A_RESET, 8'h00, reset value of reg_a, reg_x and reg_y.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  ALU result on wb_* is valid this cycle
- wb_op  in  8  ALU opcode that produced the result (ALU op encoding)
- wb_dest  in  2  00 none (CMP/BIT-style), 01 A, 10 X, 11 Y
- wb_flag_en  in  4  {N,V,Z,C} update enables from decoder
- wb_a7  in  1  bit 7 of ALU operand a
- wb_b7  in  1  bit 7 of ALU operand b
- wb_y  in  8  ALU result y
- wb_carry  in  1  ALU carry_out
- p_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV
- p_load  in  1  PLP: load P from p_load_data
- p_load_data  in  8  value pulled from stack
- reg_a, reg_x, reg_y  out  8  architectural registers
- reg_p  out  8  status {N,V,1,1,D,I,Z,C}
- carry_fwd  out  1  carry to ALU carry_in
- commit  out  1  high during the cycle a staged result is pending

Behaviour:
- Reset (async, rst_n=0):
  - reg_a, reg_x, reg_y = A_RESET; reg_p = P_RESET.
  - Staging register cleared; commit = 0.
  - Reset mid-operation drops any staged entry. Nothing is committed after reset release.
- Stage 1 (capture): at an edge with wb_valid=1, latch wb_op, wb_dest, wb_flag_en, wb_a7, wb_b7, wb_y and wb_carry; set s_valid=1. At an edge with wb_valid=0, clear s_valid. The staging register is overwritten every cycle; there is no stall.
- Stage 2 (commit): while s_valid=1, commit=1. At the next edge:
  - If dest is not none, the destination register is loaded with s_y.
  - N = s_y[7], if its enable is set.
  - Z = (s_y == 0), if its enable is set.
  - C = s_carry, if its enable is set.
  - V, if its enable is set:
    - ADD (0x21): (a7==b7) && (y7!=a7).
    - SUB (0x23): (a7!=b7) && (y7!=a7).
    - Any other op: V unchanged, regardless of the enable.
- Latency: the result is visible on reg_* one edge after the capture edge, i.e. two edges after wb_valid is presented. A wb_valid presented every cycle gives one commit per cycle.
- carry_fwd = (s_valid && s_flag_en[C]) ? s_carry : reg_p[0]. This is combinational and covers read-after-write of C between consecutive ALU ops.
- p_op and p_load act on the edge where they are sampled and are architecturally younger than the staged result:
  - On the bits they touch, they override the commit.
  - A commit on the same edge still updates the untouched bits and the destination register.
- p_load overrides both p_op and the commit on all P bits. Bits 5 and 4 of p_load_data are ignored and reg_p[5:4] always reads 1.
- Simultaneous p_op and p_load: p_load wins.
- Register width: all 8-bit, wrap-around handled by the ALU. This block performs no arithmetic beyond flag derivation.
- D and I are modified only by p_op and p_load, never by a commit.
- FSM: implicit 2-state (EMPTY / STAGED) encoded by s_valid:
  - EMPTY → STAGED on wb_valid.
  - STAGED → STAGED on wb_valid.
  - STAGED → EMPTY on !wb_valid.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (AND 0x01 … DEC 0x24).
  - WB_DEST_* encodings and P_OP_* encodings.
  - P bit indices P_C=0, P_Z=1, P_I=2, P_D=3, P_V=6, P_N=7.
- One combinational sub-module, alu_flag_calc: takes staged y, carry, a7, b7 and op; produces candidate N, Z, C, V. It is reused later by the BIT path.

Test Plan:
- Reset release → reg_p=0x34, reg_a=reg_x=reg_y=0x00, commit=0, carry_fwd=0.
- ADD result: wb_op=0x21, a7=0, b7=0, y=0x80, carry=0, dest=A, en=4'b1111 → after two edges reg_a=0x80, reg_p=0xF4 (N=1, V=1, Z=0, C=0).
- Back-to-back: SUB y=0x00 carry=1 dest=none en=1111, then next cycle ADC presented → carry_fwd=1 in the second cycle before commit. Afterwards reg_a unchanged and reg_p Z=1, C=1.
- Same-edge conflict: staged ASL (0x11) with carry=1, en C=1, and p_op=CLC on the commit edge → C=0; N and Z from the staged result still updated.
- PLP: p_load=1, p_load_data=0x00, with p_op=SEC concurrent → reg_p=0x30.
- Reset asserted while s_valid=1 (dest=X, y=0x55) → reg_x stays 0x00 after release; no commit pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, writeback encodings and status-register bit indices
package alu_pkg;
  localparam logic [7:0] OP_AND = 8'h01;
  localparam logic [7:0] OP_ORA = 8'h02;
  localparam logic [7:0] OP_EOR = 8'h03;
  localparam logic [7:0] OP_BIT = 8'h04;
  localparam logic [7:0] OP_ASL = 8'h11;
  localparam logic [7:0] OP_LSR = 8'h12;
  localparam logic [7:0] OP_ROL = 8'h13;
  localparam logic [7:0] OP_ROR = 8'h14;
  localparam logic [7:0] OP_ADD = 8'h21;
  localparam logic [7:0] OP_INC = 8'h22;
  localparam logic [7:0] OP_SUB = 8'h23;
  localparam logic [7:0] OP_DEC = 8'h24;
  localparam logic [1:0] WB_DEST_NONE = 2'd0;
  localparam logic [1:0] WB_DEST_A = 2'd1;
  localparam logic [1:0] WB_DEST_X = 2'd2;
  localparam logic [1:0] WB_DEST_Y = 2'd3;
  localparam logic [2:0] P_OP_NONE = 3'd0;
  localparam logic [2:0] P_OP_CLC = 3'd1;
  localparam logic [2:0] P_OP_SEC = 3'd2;
  localparam logic [2:0] P_OP_CLI = 3'd3;
  localparam logic [2:0] P_OP_SEI = 3'd4;
  localparam logic [2:0] P_OP_CLD = 3'd5;
  localparam logic [2:0] P_OP_SED = 3'd6;
  localparam logic [2:0] P_OP_CLV = 3'd7;
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_V = 6;
  localparam int P_N = 7;
  // flag-enable vector is {N,V,Z,C}
  localparam int FE_C = 0;
  localparam int FE_Z = 1;
  localparam int FE_V = 2;
  localparam int FE_N = 3;
  typedef struct packed {
    logic [7:0] op;
    logic [1:0] dest;
    logic [3:0] flag_en;
    logic       a7;
    logic       b7;
    logic [7:0] y;
    logic       carry;
  } wb_stage_t;
endpackage

// File: rtl/alu_flag_calc.sv
// alu_flag_calc: candidate N/Z/C/V from a staged ALU result
module alu_flag_calc
  import alu_pkg::*;
(
  input  logic [7:0] y,
  input  logic       carry,
  input  logic       a7,
  input  logic       b7,
  input  logic [7:0] op,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v,
  output logic       v_ok
);
  assign n = y[7];
  assign z = (y == 8'h00);
  assign c = carry;
  // V only has meaning for add/subtract; v_ok gates it
  assign v_ok = (op == OP_ADD) || (op == OP_SUB);
  assign v = (op == OP_SUB) ? ((a7 != b7) && (y[7] != a7)) : ((a7 == b7) && (y[7] != a7));
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: one-entry staging of ALU results, commit to A/X/Y and status P
module alu_writeback
  import alu_pkg::*;
#(
  parameter logic [7:0] P_RESET = 8'h34,
  parameter logic [7:0] A_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  input  logic [7:0] wb_op,
  input  logic [1:0] wb_dest,
  input  logic [3:0] wb_flag_en,
  input  logic       wb_a7,
  input  logic       wb_b7,
  input  logic [7:0] wb_y,
  input  logic       wb_carry,
  input  logic [2:0] p_op,
  input  logic       p_load,
  input  logic [7:0] p_load_data,
  output logic [7:0] reg_a,
  output logic [7:0] reg_x,
  output logic [7:0] reg_y,
  output logic [7:0] reg_p,
  output logic       carry_fwd,
  output logic       commit
);
  logic      s_valid;
  wb_stage_t s;
  logic      f_n, f_z, f_c, f_v, f_v_ok;
  logic [7:0] p_commit, p_next;
  alu_flag_calc u_flag (
    .y(s.y), .carry(s.carry), .a7(s.a7), .b7(s.b7), .op(s.op),
    .n(f_n), .z(f_z), .c(f_c), .v(f_v), .v_ok(f_v_ok)
  );
  always_comb begin
    p_commit = reg_p;
    p_commit[P_N] = (s_valid && s.flag_en[FE_N]) ? f_n : reg_p[P_N];
    p_commit[P_Z] = (s_valid && s.flag_en[FE_Z]) ? f_z : reg_p[P_Z];
    p_commit[P_C] = (s_valid && s.flag_en[FE_C]) ? f_c : reg_p[P_C];
    p_commit[P_V] = (s_valid && s.flag_en[FE_V] && f_v_ok) ? f_v : reg_p[P_V];
    p_next = p_commit;
    p_next[P_C] = (p_op == P_OP_CLC) ? 1'b0 : (p_op == P_OP_SEC) ? 1'b1 : p_commit[P_C];
    p_next[P_I] = (p_op == P_OP_CLI) ? 1'b0 : (p_op == P_OP_SEI) ? 1'b1 : p_commit[P_I];
    p_next[P_D] = (p_op == P_OP_CLD) ? 1'b0 : (p_op == P_OP_SED) ? 1'b1 : p_commit[P_D];
    p_next[P_V] = (p_op == P_OP_CLV) ? 1'b0 : p_commit[P_V];
    p_next = p_load ? p_load_data : p_next;
    p_next[5:4] = 2'b11;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= 1'b0;
      s <= '0;
      reg_a <= A_RESET;
      reg_x <= A_RESET;
      reg_y <= A_RESET;
      reg_p <= P_RESET;
    end else begin
      s_valid <= wb_valid;
      if (wb_valid) s <= '{op: wb_op, dest: wb_dest, flag_en: wb_flag_en, a7: wb_a7,
                           b7: wb_b7, y: wb_y, carry: wb_carry};
      reg_a <= (s_valid && s.dest == WB_DEST_A) ? s.y : reg_a;
      reg_x <= (s_valid && s.dest == WB_DEST_X) ? s.y : reg_x;
      reg_y <= (s_valid && s.dest == WB_DEST_Y) ? s.y : reg_y;
      reg_p <= p_next;
    end
  end
  assign commit = s_valid;
  // forward the in-flight carry so chained ADC/SBC/ROL see it before commit
  assign carry_fwd = (s_valid && s.flag_en[FE_C]) ? s.carry : reg_p[P_C];
endmodule
